// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer/counter device: register word offsets, MODE encodings and
// FSM state encoding. The bus bridge imports the same offsets.
package timer_counter_pkg;

  localparam int unsigned AddrW = 2;
  localparam int unsigned DataW = 32;

  // Register word offsets within the device window
  localparam logic [AddrW-1:0] AddrCtrl   = 2'd0;
  localparam logic [AddrW-1:0] AddrPreset = 2'd1;
  localparam logic [AddrW-1:0] AddrCount  = 2'd2;

  // CTRL.MODE encodings; 2'b1x behaves as one-shot
  localparam logic [1:0] ModeOneShot    = 2'b00;
  localparam logic [1:0] ModeAutoReload = 2'b01;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_counter_if.sv
// Register-bus interface of the timer/counter.
//   addr : word offset (0 CTRL, 1 PRESET, 2 COUNT, 3 unused)
//   we   : write strobe, sampled on the clock edge
//   din  : write data
//   dout : combinational read data for addr
//   irq  : registered interrupt request
// master = bridge side, slave = timer side.
interface timer_counter_if;
  import timer_counter_pkg::*;

  logic [AddrW-1:0] addr;
  logic             we;
  logic [DataW-1:0] din;
  logic [DataW-1:0] dout;
  logic             irq;

  modport master (output addr, output we, output din, input dout, input irq);
  modport slave  (input addr, input we, input din, output dout, output irq);

endinterface

// File: rtl/timer_counter.sv
// Programmable 32-bit down-counting timer with one-shot and auto-reload modes.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : register bus (addr/we/din in, dout/irq out)
// CTRL = {IM, MODE[1:0], EN}; PRESET is R/W; COUNT is read-only.
// irq = IM & IRQF, registered so it leaves the block straight from a flop.
module timer_counter (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);
  import timer_counter_pkg::*;

  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             im_q, im_d;
  logic             irqf_q, irqf_d;
  logic             irq_q, irq_d;
  logic [DataW-1:0] preset_q, preset_d;
  logic [DataW-1:0] count_q, count_d;
  logic [DataW-1:0] rdata;
  logic             ctrl_wr;
  logic             preset_wr;

  assign ctrl_wr   = bus.we && (bus.addr == AddrCtrl);
  assign preset_wr = bus.we && (bus.addr == AddrPreset);

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    irqf_d   = irqf_q;
    preset_d = preset_q;
    count_d  = count_q;

    case (state_q)
      StIdle: begin
        if (en_q) begin
          state_d = StLoad;
          irqf_d  = 1'b0;
        end
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en_q) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Terminal count; also covers PRESET=0 so COUNT never wraps
          count_d = '0;
          irqf_d  = 1'b1;
          state_d = StInt;
        end
      end
      StInt: begin
        if (mode_q == ModeAutoReload) begin
          irqf_d = 1'b0;
        end else begin
          en_d = 1'b0;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A CTRL write overrides any same-cycle FSM update of EN/IRQF
    if (ctrl_wr) begin
      en_d   = bus.din[0];
      mode_d = bus.din[2:1];
      im_d   = bus.din[3];
      irqf_d = 1'b0;
    end
    if (preset_wr) begin
      preset_d = bus.din;
    end
  end

  assign irq_d = im_d & irqf_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      mode_q   <= ModeOneShot;
      im_q     <= 1'b0;
      irqf_q   <= 1'b0;
      irq_q    <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      irqf_q   <= irqf_d;
      irq_q    <= irq_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.addr)
      AddrCtrl:   rdata = {28'd0, im_q, mode_q, en_q};
      AddrPreset: rdata = preset_q;
      AddrCount:  rdata = count_q;
      default:    rdata = '0;
    endcase
  end

  assign bus.dout = rdata;
  assign bus.irq  = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter. Inputs change and outputs are sampled
// around the falling clock edge; the DUT acts on the rising edge.
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  timer_counter_if bus ();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write one register; returns at the falling edge after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.we   = 1'b1;
    @(negedge clk);
    bus.we   = 1'b0;
    bus.din  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.dout;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_dout addr=%0d: got %h want 00000000", a, d);
      end
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b want 0", bus.irq);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_regs();
    logic [31:0] d;
    wr(AddrCtrl, 32'hFFFF_FFF0);
    rd(AddrCtrl, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL ctrl_upper_bits: got %h want 00000000", d);
    end
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL addr3_read: got %h want 00000000", d);
    end
    wr(AddrPreset, 32'hA5A5_1234);
    rd(AddrPreset, d);
    checks++;
    if (d !== 32'hA5A5_1234) begin
      errors++;
      $display("FAIL preset_rw: got %h want a5a51234", d);
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    logic        exp_irq;
    wr(AddrPreset, 32'd3);
    wr(AddrCtrl, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_irq = (k >= 5);
      checks++;
      if (bus.irq !== exp_irq) begin
        errors++;
        $display("FAIL one_shot_irq edge=%0d: got %b want %b", k, bus.irq, exp_irq);
      end
      if (k >= 2 && k <= 5) begin
        rd(AddrCount, d);
        checks++;
        if (d !== 32'(5 - k)) begin
          errors++;
          $display("FAIL one_shot_count edge=%0d: got %0d want %0d", k, d, 5 - k);
        end
      end
    end
    rd(AddrCtrl, d);
    checks++;
    if (d !== 32'h8) begin
      errors++;
      $display("FAIL one_shot_ctrl_after: got %h want 00000008", d);
    end
    wr(AddrCtrl, 32'h0);
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_ctrl_clear: got %b want 0", bus.irq);
    end
  endtask

  task automatic test_auto_reload();
    logic exp_irq;
    wr(AddrPreset, 32'd2);
    wr(AddrCtrl, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_irq = (k >= 4) && (((k - 4) % 5) == 0);
      checks++;
      if (bus.irq !== exp_irq) begin
        errors++;
        $display("FAIL auto_reload_irq edge=%0d: got %b want %b", k, bus.irq, exp_irq);
      end
    end
    wr(AddrCtrl, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_masked();
    logic [31:0] d;
    wr(AddrPreset, 32'd2);
    wr(AddrCtrl, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.irq !== 1'b0) begin
        errors++;
        $display("FAIL masked_irq edge=%0d: got %b want 0", k, bus.irq);
      end
    end
    rd(AddrCtrl, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL masked_ctrl_after: got %h want 00000000", d);
    end
    wr(AddrCtrl, 32'h8);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.irq !== 1'b0) begin
        errors++;
        $display("FAIL masked_unmask_irq cyc=%0d: got %b want 0", k, bus.irq);
      end
      @(negedge clk);
    end
    wr(AddrCtrl, 32'h0);
  endtask

  task automatic test_disable_mid_count();
    logic [31:0] d;
    wr(AddrPreset, 32'd10);
    wr(AddrCtrl, 32'h1);
    repeat (6) @(negedge clk);
    rd(AddrCount, d);
    checks++;
    if (d !== 32'd6) begin
      errors++;
      $display("FAIL disable_pre_count: got %0d want 6", d);
    end
    wr(AddrCtrl, 32'h0);
    repeat (3) @(negedge clk);
    rd(AddrCount, d);
    checks++;
    if (d !== 32'd5) begin
      errors++;
      $display("FAIL disable_frozen_count: got %0d want 5", d);
    end
    checks++;
    if (dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL disable_state: got %0d want %0d", dut.state_q, StIdle);
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL disable_irq: got %b want 0", bus.irq);
    end
    wr(AddrCtrl, 32'h1);
    repeat (2) @(negedge clk);
    rd(AddrCount, d);
    checks++;
    if (d !== 32'd10) begin
      errors++;
      $display("FAIL disable_reload: got %0d want 10", d);
    end
    wr(AddrCtrl, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ctrl_priority();
    logic [31:0] d;
    wr(AddrPreset, 32'd1);
    wr(AddrCtrl, 32'h9);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL prio_irq_set: got %b want 1", bus.irq);
    end
    // This write lands on the INT edge where the FSM would clear EN
    wr(AddrCtrl, 32'h9);
    rd(AddrCtrl, d);
    checks++;
    if (d !== 32'h9) begin
      errors++;
      $display("FAIL prio_ctrl_wins: got %h want 00000009", d);
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL prio_irq_cleared: got %b want 0", bus.irq);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.irq !== (k == 3)) begin
        errors++;
        $display("FAIL prio_rearm edge=%0d: got %b want %b", k, bus.irq, (k == 3));
      end
    end
    wr(AddrCtrl, 32'h0);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    wr(AddrPreset, 32'd10);
    wr(AddrCtrl, 32'h9);
    repeat (8) @(negedge clk);
    rd(AddrCount, d);
    checks++;
    if (d !== 32'd4) begin
      errors++;
      $display("FAIL areset_pre_count: got %0d want 4", d);
    end
    reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL areset_dout addr=%0d: got %h want 00000000", a, d);
      end
    end
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL areset_irq: got %b want 0", bus.irq);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (bus.irq !== 1'b0) begin
        errors++;
        $display("FAIL areset_no_irq cyc=%0d: got %b want 0", k, bus.irq);
      end
    end
    rd(AddrCount, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL areset_count_idle: got %0d want 0", d);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] d;
    for (int p = 0; p < 2; p++) begin
      wr(AddrPreset, 32'(p));
      wr(AddrCtrl, 32'h9);
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        checks++;
        if (bus.irq !== (k >= 3)) begin
          errors++;
          $display("FAIL boundary_preset%0d_irq edge=%0d: got %b want %b",
                   p, k, bus.irq, (k >= 3));
        end
      end
      rd(AddrCount, d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL boundary_preset%0d_no_wrap: got %h want 00000000", p, d);
      end
      wr(AddrCtrl, 32'h0);
    end
    wr(AddrPreset, 32'd8);
    wr(AddrCtrl, 32'h1);
    repeat (4) @(negedge clk);
    wr(AddrCount, 32'h55);
    rd(AddrCount, d);
    checks++;
    if (d !== 32'd5) begin
      errors++;
      $display("FAIL boundary_count_write_ignored: got %0d want 5", d);
    end
    wr(AddrPreset, 32'd100);
    rd(AddrCount, d);
    checks++;
    if (d !== 32'd4) begin
      errors++;
      $display("FAIL boundary_preset_during_cnt: got %0d want 4", d);
    end
    @(negedge clk);
    rd(AddrCount, d);
    checks++;
    if (d !== 32'd3) begin
      errors++;
      $display("FAIL boundary_count_continues: got %0d want 3", d);
    end
    wr(AddrCtrl, 32'h0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b0;
    bus.addr = '0;
    bus.we   = 1'b0;
    bus.din  = '0;
    test_reset();
    test_regs();
    test_one_shot();
    test_auto_reload();
    test_masked();
    test_disable_mid_count();
    test_ctrl_priority();
    test_async_reset();
    test_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
